// File: rtl/result_stream_reader.sv
// Drains the result memory in ascending address order onto a valid/ready stream.
// Reads are credit-limited so a 2-entry buffer absorbs the 1-cycle read latency.
module result_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_WORDS  = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  en_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [DATA_WIDTH-1:0] dout_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [ADDR_WIDTH:0] WORDS_C = (ADDR_WIDTH+1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH:0] LAST_C  = (ADDR_WIDTH+1)'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH:0]   acc_cnt_q, acc_cnt_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic       push;
    logic       pop;
    logic       issue;
    logic [2:0] used;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        m_valid = (count_q != 2'd0);
        m_data  = m_valid ? fifo_q[rd_ptr_q] : '0;
        m_last  = m_valid && (acc_cnt_q == LAST_C);
        pop     = m_valid && m_ready;
        push    = pend_q;

        // A pop this cycle frees its slot for a read issued this same cycle.
        used  = 3'(count_q) + 3'(pend_q) - 3'(pop);
        issue = (state_q == RUN) && (issue_cnt_q < WORDS_C) && (used < 3'd2);

        en_out   = issue;
        addr_out = issue_cnt_q[ADDR_WIDTH-1:0];
        pend_d   = issue;
        if (issue) begin
            issue_cnt_d = issue_cnt_q + ONE_C;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = dout_out;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d  = ~rd_ptr_q;
            acc_cnt_d = acc_cnt_q + ONE_C;
        end
        count_d = count_q + 2'(push) - 2'(pop);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    issue_cnt_d = '0;
                    acc_cnt_d   = '0;
                end
            end
            RUN: begin
                if (pop && m_last) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy = (state_q != IDLE);
        done = (state_q == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            acc_cnt_q   <= '0;
            pend_q      <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            pend_q      <= pend_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule
